// File: rtl/bcd_sub_serial.sv
// bcd_sub_serial: digit-serial packed-BCD subtractor Z = X - Y, LSD first, start/busy/done handshake
//   Optional feature macro BCD_SUB_SIGNMAG_EN: adds a FIX pass so a negative result is
//   returned as its magnitude (B_out acts as sign); without it Z_out is the ten's complement.
//   Ports:
//     CLK_in    rising-edge clock
//     RSTn_in   synchronous active-low reset
//     Start_in  request, sampled only in IDLE
//     X_in      minuend, packed BCD, digit 0 in [3:0]
//     Y_in      subtrahend, packed BCD
//     Z_out     result, packed BCD (valid from Done_out until next accepted start)
//     B_out     final borrow (X < Y)
//     Err_out   an operand nibble was > 9
//     Busy_out  operation in progress
//     Done_out  one-cycle result-valid pulse
module bcd_sub_serial #(
    parameter int DIGITS = 4
) (
    input  logic                  CLK_in,
    input  logic                  RSTn_in,
    input  logic                  Start_in,
    input  logic [4*DIGITS-1:0]   X_in,
    input  logic [4*DIGITS-1:0]   Y_in,
    output logic [4*DIGITS-1:0]   Z_out,
    output logic                  B_out,
    output logic                  Err_out,
    output logic                  Busy_out,
    output logic                  Done_out
);
    localparam int KW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
`ifdef BCD_SUB_SIGNMAG_EN
        FIX,
`endif
        DONE
    } state_t;

    state_t st, nxt;
    logic [4*DIGITS-1:0] x, y, z;
    logic [KW-1:0] k;
    logic b, bo, err, bad, fix, last, neg;
    logic [3:0] a, s, zd;
    logic [4:0] d;

`ifdef BCD_SUB_SIGNMAG_EN
    assign fix = st == FIX;
`else
    assign fix = 1'b0;
`endif

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            bad = bad | (X_in[i*4 +: 4] > 4'd9) | (Y_in[i*4 +: 4] > 4'd9);
    end

    // FIX pass computes 0 - Z (ten's complement of Z) in place, which is the magnitude
    always_comb begin
        a    = fix ? 4'd0 : x[k*4 +: 4];
        s    = fix ? z[k*4 +: 4] : y[k*4 +: 4];
        d    = {1'b0, a} - {1'b0, s} - {4'd0, b};
        neg  = d[4];
        zd   = neg ? d[3:0] + 4'd10 : d[3:0];
        last = k == KW'(DIGITS - 1);
    end

    always_ff @(posedge CLK_in)
        st <= !RSTn_in ? IDLE : nxt;

    always_comb begin
        nxt = st;
        case (st)
            IDLE: nxt = Start_in ? (bad ? DONE : SUB) : IDLE;
`ifdef BCD_SUB_SIGNMAG_EN
            SUB:  nxt = last ? (neg ? FIX : DONE) : SUB;
            FIX:  nxt = last ? DONE : FIX;
`else
            SUB:  nxt = last ? DONE : SUB;
`endif
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_in) begin
        if (!RSTn_in) begin
            x   <= '0;
            y   <= '0;
            z   <= '0;
            k   <= '0;
            b   <= 1'b0;
            bo  <= 1'b0;
            err <= 1'b0;
        end else if (st == IDLE) begin
            if (Start_in) begin
                x   <= X_in;
                y   <= Y_in;
                z   <= '0;
                k   <= '0;
                b   <= 1'b0;
                bo  <= 1'b0;
                err <= bad;
            end
        end else if (st == SUB || fix) begin
            z[k*4 +: 4] <= zd;
            k <= last ? '0 : k + 1'b1;
            // borrow is cleared on the last digit so a following FIX pass starts clean
            b <= last ? 1'b0 : neg;
            if (last && !fix)
                bo <= neg;
        end
    end

    assign Z_out    = z;
    assign B_out    = bo;
    assign Err_out  = err;
    assign Busy_out = (st == SUB) | fix;
    assign Done_out = st == DONE;
endmodule

// File: tb/tb_bcd_sub_serial.sv
// tb_bcd_sub_serial: randomized scoreboard bench for bcd_sub_serial against an integer-arithmetic model
module tb_bcd_sub_serial;
    localparam int D = 4;

    logic CLK_in = 1'b0, RSTn_in = 1'b0, Start_in = 1'b0;
    logic [15:0] X_in = '0, Y_in = '0;
    logic [15:0] Z_out;
    logic B_out, Err_out, Busy_out, Done_out;

    bcd_sub_serial #(.DIGITS(D)) dut (
        .CLK_in(CLK_in), .RSTn_in(RSTn_in), .Start_in(Start_in),
        .X_in(X_in), .Y_in(Y_in), .Z_out(Z_out), .B_out(B_out),
        .Err_out(Err_out), .Busy_out(Busy_out), .Done_out(Done_out)
    );

    always #5 CLK_in = ~CLK_in;

    typedef struct {
        logic [15:0] z;
        logic b;
        logic e;
        int done;
    } exp_t;

    exp_t q[$];
    int checks = 0, failures = 0, cyc = 0, next_free = 0;
    bit acc = 0, hold_v = 0;
    logic [15:0] held_z;
    logic held_b, held_e;

    always @(posedge CLK_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit is_bad(input logic [15:0] v);
        for (int i = 0; i < D; i++)
            if (v[i*4 +: 4] > 4'd9) return 1;
        return 0;
    endfunction

    function automatic int to_int(input logic [15:0] v);
        int r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r = '0;
        for (int i = 0; i < D; i++) begin
            r[i*4 +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    // e is the edge at which Start is accepted; that edge counts as the first of the latency
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input int e, output int lat);
        exp_t r;
        int diff;
        r.e = 0;
        r.b = 0;
        if (is_bad(x) || is_bad(y)) begin
            r.z = '0;
            r.e = 1;
            lat = 1;
        end else begin
            diff = to_int(x) - to_int(y);
            lat = D + 1;
            if (diff >= 0) r.z = to_bcd(diff);
            else begin
                r.b = 1;
`ifdef BCD_SUB_SIGNMAG_EN
                r.z = to_bcd(-diff);
                lat = 2 * D + 1;
`else
                r.z = to_bcd(10000 + diff);
`endif
            end
        end
        r.done = e + lat - 1;
        return r;
    endfunction

    always @(negedge CLK_in) begin
        exp_t ex;
        int lat;
        if (Done_out && q.size() > 0) begin
            ex = q.pop_front();
            chk("z", Z_out, ex.z);
            chk("b", B_out, ex.b);
            chk("err", Err_out, ex.e);
            chk("done_cycle", cyc, ex.done);
            chk("busy_in_done", Busy_out, 0);
            held_z = ex.z;
            held_b = ex.b;
            held_e = ex.e;
            hold_v = 1;
        end else if (Done_out) begin
            chk("unexpected_done", Done_out, 0);
        end else if (q.size() > 0 && cyc > q[0].done) begin
            chk("done_missing", Done_out, 1);
            void'(q.pop_front());
        end else if (hold_v) begin
            chk("hold_z", Z_out, held_z);
            chk("hold_b", B_out, held_b);
            chk("hold_err", Err_out, held_e);
        end
        if (!RSTn_in) begin
            q.delete();
            hold_v = 0;
            next_free = cyc + 2;
        end else if (Start_in && cyc + 1 >= next_free) begin
            ex = model(X_in, Y_in, cyc + 1, lat);
            q.push_back(ex);
            next_free = cyc + 1 + lat + 1;
            hold_v = 0;
            acc = 1;
        end
    end

    task automatic op(input logic [15:0] x, input logic [15:0] y, input int gap);
        int n = 0;
        X_in = x;
        Y_in = y;
        Start_in = 1;
        do begin
            @(posedge CLK_in);
            #1;
            n++;
        end while (!acc && n < 100);
        chk("accept", acc, 1);
        acc = 0;
        Start_in = 0;
        X_in = 16'($urandom);
        Y_in = 16'($urandom);
        repeat (gap) @(posedge CLK_in);
        #1;
    endtask

    function automatic logic [15:0] rnd_bcd();
        logic [15:0] r;
        for (int i = 0; i < D; i++)
            r[i*4 +: 4] = ($urandom_range(0, 63) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        return r;
    endfunction

    initial begin
        int n;
        logic [15:0] rx;
        repeat (3) @(posedge CLK_in);
        #1;
        chk("rst_z", Z_out, 0);
        chk("rst_b", B_out, 0);
        chk("rst_err", Err_out, 0);
        chk("rst_busy", Busy_out, 0);
        chk("rst_done", Done_out, 0);
        RSTn_in = 1;
        @(posedge CLK_in);
        #1;
        op(16'h5321, 16'h1234, 6);
        op(16'h0100, 16'h0001, 3);
        op(16'h1234, 16'h5321, 4);
        op(16'h12A4, 16'h0001, 2);
        op(16'h0000, 16'h0001, 0);
        op(16'h9999, 16'h0000, 1);
        X_in = 16'h9999;
        Y_in = 16'h9999;
        Start_in = 1;
        repeat (10) @(posedge CLK_in);
        #1;
        Start_in = 0;
        acc = 0;
        repeat (8) @(posedge CLK_in);
        #1;
        op(16'h5321, 16'h1234, 0);
        @(posedge CLK_in);
        #1;
        RSTn_in = 0;
        @(posedge CLK_in);
        #1;
        RSTn_in = 1;
        @(negedge CLK_in);
        chk("midrst_z", Z_out, 0);
        chk("midrst_b", B_out, 0);
        chk("midrst_err", Err_out, 0);
        chk("midrst_busy", Busy_out, 0);
        chk("midrst_done", Done_out, 0);
        @(posedge CLK_in);
        #1;
        op(16'h0010, 16'h0009, 3);
        for (int i = 0; i < 150; i++) begin
            rx = rnd_bcd();
            op(rx, ($urandom_range(0, 9) == 0) ? rx : rnd_bcd(), $urandom_range(0, 3));
        end
        n = 0;
        while (q.size() > 0 && n < 100) begin
            @(posedge CLK_in);
            n++;
        end
        #1;
        chk("drain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bcd_sub_serial.md
# bcd_sub_serial

Digit-serial multi-digit BCD subtractor, the inverse operation of the one-digit BCD adder in the BCD arithmetic set. Computes Z = X − Y on packed BCD operands one decimal digit per clock, least significant digit first, with a start/busy/done handshake. It serves as the subtraction path beside the BCD adder chain and feeds display and control logic that consume packed BCD.

## Interface
- DIGITS, 4, number of BCD digits per operand (≥1); operand width 4*DIGITS
- CLK_in  input  1  clock, rising edge
- RSTn_in  input  1  reset, synchronous, active-low
- Start_in  input  1  request; sampled only in IDLE
- X_in  input  4*DIGITS  minuend, packed BCD, digit 0 in [3:0]
- Y_in  input  4*DIGITS  subtrahend, packed BCD
- Z_out  output  4*DIGITS  result, packed BCD
- B_out  output  1  final borrow (X < Y)
- Err_out  output  1  an operand nibble was > 9
- Busy_out  output  1  operation in progress
- Done_out  output  1  one-cycle result-valid pulse

## Operation
- States: IDLE, SUB, FIX (only with macro), DONE.
- IDLE: Busy_out=0. Start_in=1 at an edge latches X_in, Y_in, clears digit index k and borrow b.
  - Any nibble of X_in or Y_in > 9: go to DONE with Z_out=0, B_out=0, Err_out=1; no SUB cycles.
  - Otherwise Err_out=0, go to SUB.
- SUB: per edge, d = X[k] − Y[k] − b (signed 5-bit); if d < 0 then Z[k] = d + 10, b = 1, else Z[k] = d, b = 0; k increments. After digit DIGITS−1: B_out = b; go to FIX if macro defined and b = 1, else DONE.
- FIX: same datapath with minuend forced to 0 and subtrahend = current Z, borrow cleared at entry; yields the magnitude. Runs DIGITS cycles, then DONE.
- DONE: Done_out=1 for exactly this cycle; next state IDLE. Start_in in DONE is ignored.
- Start_in in SUB/FIX/DONE is ignored; latched operands never change mid-operation.
- Z_out, B_out, Err_out hold their values from DONE until the next accepted Start (Z_out is updated per digit during SUB/FIX and is not valid until Done_out).
- Reset (RSTn_in=0 at an edge), including mid-operation: state IDLE; Z_out=0, B_out=0, Err_out=0, Busy_out=0, Done_out=0; internal k, b cleared.

## Timing
- Start accepted at edge 0; Busy_out=1 from edge 0 until edge at which DONE is entered, then 0 (Busy_out=0 in DONE).
- Normal latency: Done_out high in the cycle after edge DIGITS+1 → Done rises DIGITS+1 edges after Start edge.
- With FIX pass: DONE entered 2*DIGITS+1 edges after Start.
- Error: DONE entered 1 edge after Start.
- Back-to-back: earliest next Start accepted at the edge leaving DONE+1 (i.e. in IDLE); minimum period DIGITS+2 cycles.
- Z of equal operands: all zeros, B_out=0.

## Configuration
- BCD_SUB_SIGNMAG_EN defined: FIX state compiled in; when X < Y, Z_out = |X − Y| in BCD and B_out=1 (sign flag).
- Undefined: no FIX state; when X < Y, Z_out = ten's complement 10^DIGITS − |X − Y|, B_out=1; latency always DIGITS+1.

## Test plan (DIGITS=4)
- X=5321, Y=1234, Start pulse -> Z_out=4087, B_out=0, Err_out=0, Done_out high for 1 cycle 5 edges after Start.
- X=0100, Y=0001 -> Z_out=0099, B_out=0 (borrow ripples through two zero digits).
- X=1234, Y=5321 -> without macro Z_out=5913, B_out=1, Done at 5 edges; with BCD_SUB_SIGNMAG_EN Z_out=4087, B_out=1, Done at 9 edges.
- X=12A4, Y=0001 -> Err_out=1, Z_out=0000, B_out=0, Done 1 edge after Start.
- Start held high for 10 cycles with X=9999, Y=9999 -> exactly one accepted operation per IDLE visit, each result Z_out=0000, B_out=0; operands changed while Busy_out=1 do not alter result.
- RSTn_in low at 2nd SUB cycle -> next cycle all outputs 0, state IDLE; following Start X=0010, Y=0009 -> Z_out=0001.
